mul_hilo_ctrl: RTL and testbench

//  EX-stage sequencer between the pipeline and BoothMultipilcation: latches MULT operands and drives run.

---
 rtl/mul_hilo_ctrl_pkg.sv | 41 ++++
 rtl/mul_hilo_ctrl_if.sv | 29 ++
 rtl/mul_hilo_ctrl_hilo_regs.sv | 42 ++++
 rtl/mul_hilo_ctrl.sv | 113 +++++++++++
 tb/tb_mul_hilo_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply sequencer:
// widths, timeout default, FSM states, request decode.
package mul_hilo_ctrl_pkg;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_TIMEOUT = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_MULT = 3'd1,
    REQ_MTHI = 3'd2,
    REQ_MTLO = 3'd3,
    REQ_MFHI = 3'd4,
    REQ_MFLO = 3'd5
  } req_t;

  // Decode is one-hot; on overlap the earliest wins.
  function automatic req_t req_pick(
    input logic mult,
    input logic mthi,
    input logic mtlo,
    input logic mfhi,
    input logic mflo
  );
    req_t r;
    r = REQ_NONE;
    if (mult)      r = REQ_MULT;
    else if (mthi) r = REQ_MTHI;
    else if (mtlo) r = REQ_MTLO;
    else if (mfhi) r = REQ_MFHI;
    else if (mflo) r = REQ_MFLO;
    return r;
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// Run/valid handshake to the multiplier.
// master: sequencer side; slave: multiplier side.
interface mul_hilo_ctrl_if #(
  parameter int WIDTH = 32
);

  logic               mul_run;
  logic [WIDTH-1:0]   mul_multiplicand;
  logic [WIDTH-1:0]   mul_multiplier;
  logic               mul_isValid;
  logic [2*WIDTH-1:0] mul_result;

  modport master (
    output mul_run,
    output mul_multiplicand,
    output mul_multiplier,
    input  mul_isValid,
    input  mul_result
  );

  modport slave (
    input  mul_run,
    input  mul_multiplicand,
    input  mul_multiplier,
    output mul_isValid,
    output mul_result
  );

endinterface

// File: rtl/mul_hilo_ctrl_hilo_regs.sv
// HI/LO register pair: product write, MT write, MF read mux.
// Ports: clk, rst_n, prod_we/prod, hi_we/lo_we/wdata, rd_hi/rd_lo/rdata.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prod_we,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               rd_hi,
  input  logic               rd_lo,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Product writes only happen in RUN and MT writes
  // only in IDLE, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (prod_we) begin
      hi <= prod[2*WIDTH-1:WIDTH];
      lo <= prod[WIDTH-1:0];
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_hi)      rdata = hi;
    else if (rd_lo) rdata = lo;
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage sequencer feeding the multiplier and owning HI/LO.
// Ports: clk, rst_n, ex_* requests/operands, mul (master), hilo_rdata, stall, busy, mul_err.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_mult,
  input  logic             ex_mthi,
  input  logic             ex_mtlo,
  input  logic             ex_mfhi,
  input  logic             ex_mflo,
  input  logic [WIDTH-1:0] ex_rs_val,
  input  logic [WIDTH-1:0] ex_rt_val,
  mul_hilo_ctrl_if.master  mul,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall,
  output logic             busy,
  output logic             mul_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX  = '1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             err;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  req_t req;
  logic idle;
  logic any_req;
  logic prod_we;

  assign req     = req_pick(ex_mult, ex_mthi, ex_mtlo,
                            ex_mfhi, ex_mflo);
  assign idle    = (state == IDLE);
  assign busy    = !idle;
  assign any_req = ex_mult | ex_mthi | ex_mtlo
                 | ex_mfhi | ex_mflo;
  assign stall   = busy & any_req;
  assign prod_we = (state == RUN) & mul.mul_isValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      run    <= 1'b0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req == REQ_MULT) begin
            mcand  <= ex_rs_val;
            mplier <= ex_rt_val;
            err    <= 1'b0;
            cnt    <= '0;
            run    <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt != CMAX) cnt <= cnt + 1'b1;
          if (mul.mul_isValid) begin
            run   <= 1'b0;
            state <= GAP;
          end else if (cnt == CLAST) begin
            err   <= 1'b1;
            run   <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          // One low cycle lets the multiplier rearm.
          state <= IDLE;
        end
        default: begin
          run   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign mul.mul_run          = run;
  assign mul.mul_multiplicand = mcand;
  assign mul.mul_multiplier   = mplier;
  assign mul_err              = err;

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk     (clk),
    .rst_n   (rst_n),
    .prod_we (prod_we),
    .prod    (mul.mul_result),
    .hi_we   (idle && req == REQ_MTHI),
    .lo_we   (idle && req == REQ_MTLO),
    .wdata   (ex_rs_val),
    .rd_hi   (req == REQ_MFHI),
    .rd_lo   (req == REQ_MFLO),
    .rdata   (hilo_rdata)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl: directed cases
// plus random ops against a HI/LO reference model.
module tb_mul_hilo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_mult, ex_mthi, ex_mtlo;
  logic        ex_mfhi, ex_mflo;
  logic [31:0] ex_rs_val, ex_rt_val;
  logic [31:0] hilo_rdata;
  logic        stall, busy, mul_err;

  mul_hilo_ctrl_if #(.WIDTH(32)) mif ();

  mul_hilo_ctrl #(
    .WIDTH   (32),
    .TIMEOUT (80)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_mult    (ex_mult),
    .ex_mthi    (ex_mthi),
    .ex_mtlo    (ex_mtlo),
    .ex_mfhi    (ex_mfhi),
    .ex_mflo    (ex_mflo),
    .ex_rs_val  (ex_rs_val),
    .ex_rt_val  (ex_rt_val),
    .mul        (mif),
    .hilo_rdata (hilo_rdata),
    .stall      (stall),
    .busy       (busy),
    .mul_err    (mul_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: valid during the lat-th
  // cycle of run; lat == 0 never answers. spur drives
  // a garbage valid whenever run is low.
  int                 lat;
  bit                 spur;
  logic [7:0]         mc;
  logic signed [63:0] mprod;

  always @(posedge clk) begin
    if (!mif.mul_run) mc <= 8'd0;
    else              mc <= mc + 8'd1;
  end

  assign mprod = $signed(mif.mul_multiplicand)
               * $signed(mif.mul_multiplier);
  assign mif.mul_isValid = mif.mul_run
    ? (lat != 0 && int'(mc) == lat - 1) : spur;
  assign mif.mul_result = mif.mul_run
    ? mprod : 64'hBAD0_BAD0_BAD0_BAD0;

  int cmp_n;
  int err_n;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Scoreboard queues and reference HI/LO.
  logic [31:0] rd_q[$];
  int          len_q[$];
  bit          errq[$];
  logic [31:0] ref_hi, ref_lo;

  // Monitor: reads are checked when served, runs when
  // mul_run falls, the GAP on the following cycle.
  int run_len;
  bit gap_chk;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      gap_chk = 0;
    end else begin
      if (gap_chk) begin
        check("gap_one_cycle", {63'd0, busy}, 64'd0);
        gap_chk = 0;
      end
      if (mif.mul_run) begin
        if (run_len == 0)
          check("err_clr_on_accept", {63'd0, mul_err}, 64'd0);
        run_len++;
      end else if (run_len > 0) begin
        if (len_q.size() == 0) begin
          check("run_unexpected", 64'd1, 64'd0);
        end else begin
          check("run_len", 64'(run_len),
                64'(len_q.pop_front()));
          check("run_err", {63'd0, mul_err},
                {63'd0, errq.pop_front()});
        end
        check("gap_busy", {63'd0, busy}, 64'd1);
        gap_chk = 1;
        run_len = 0;
      end
      if (!busy && (ex_mfhi || ex_mflo) &&
          !(ex_mult || ex_mthi || ex_mtlo)) begin
        if (rd_q.size() == 0)
          check("read_unexpected", 64'd1, 64'd0);
        else
          check("hilo_rdata", {32'd0, hilo_rdata},
                {32'd0, rd_q.pop_front()});
      end
    end
  end

  // Kinds: 0 MULT, 1 MTHI, 2 MTLO, 3 MFHI, 4 MFLO,
  // 5 MULT+MFHI together, 6 MTHI+MTLO together.
  task automatic issue(input int k,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int l,
                       output int stalls);
    logic signed [63:0] p;
    bit done;
    ex_mult   = (k == 0 || k == 5);
    ex_mthi   = (k == 1 || k == 6);
    ex_mtlo   = (k == 2 || k == 6);
    ex_mfhi   = (k == 3 || k == 5);
    ex_mflo   = (k == 4);
    ex_rs_val = a;
    ex_rt_val = b;
    case (k)
      0, 5: begin
        if (l == 0 || l > 80) begin
          len_q.push_back(80);
          errq.push_back(1'b1);
        end else begin
          p = $signed(a) * $signed(b);
          ref_hi = p[63:32];
          ref_lo = p[31:0];
          len_q.push_back(l);
          errq.push_back(1'b0);
        end
      end
      1, 6: ref_hi = a;
      2:    ref_lo = a;
      3:    rd_q.push_back(ref_hi);
      4:    rd_q.push_back(ref_lo);
      default: ;
    endcase
    stalls = 0;
    done   = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else        stalls++;
    end
    if (!done) check("stall_timeout", 64'd1, 64'd0);
    if (k == 0 || k == 5) begin
      lat  = l;
      spur = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    ex_mult = 0; ex_mthi = 0; ex_mtlo = 0;
    ex_mfhi = 0; ex_mflo = 0;
  endtask

  int st;
  int l;
  int g;

  initial begin
    cmp_n = 0; err_n = 0;
    lat = 0; spur = 0;
    ref_hi = '0; ref_lo = '0;
    rst_n = 0;
    ex_mult = 0; ex_mthi = 0; ex_mtlo = 0;
    ex_mfhi = 0; ex_mflo = 0;
    ex_rs_val = '0; ex_rt_val = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_run", {63'd0, mif.mul_run}, 64'd0);
    check("rst_err", {63'd0, mul_err}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);

    // 4 * -7 with a 34-cycle multiplier.
    issue(0, 32'd4, 32'hFFFF_FFF9, 34, st);
    check("mult_no_stall", 64'(st), 64'd0);
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);

    // MFHI right behind MULT stalls through RUN+GAP.
    issue(0, 32'd3, 32'd5, 20, st);
    issue(3, 0, 0, 0, st);
    check("mf_stall_cycles", 64'(st), 64'd21);
    issue(4, 0, 0, 0, st);

    // Back-to-back MULTs.
    issue(0, 32'd2, 32'd3, 10, st);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12, st);
    check("mult2_stall_cycles", 64'(st), 64'd11);
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);

    // Timeout keeps HI/LO, error is sticky until next MULT.
    issue(0, 32'h1234_5678, 32'h9ABC_DEF0, 0, st);
    issue(3, 0, 0, 0, st);
    check("err_sticky", {63'd0, mul_err}, 64'd1);
    issue(4, 0, 0, 0, st);
    issue(0, 32'd6, 32'd7, 5, st);
    issue(4, 0, 0, 0, st);

    // Valid arriving on the last allowed cycle still wins.
    issue(0, 32'd100, 32'd100, 80, st);
    issue(4, 0, 0, 0, st);

    // Async reset in the middle of a run.
    issue(0, 32'h7FFF_FFFF, 32'd2, 50, st);
    repeat (9) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("async_run_drop", {63'd0, mif.mul_run}, 64'd0);
    check("async_busy", {63'd0, busy}, 64'd0);
    len_q.delete();
    errq.delete();
    rd_q.delete();
    ref_hi = '0;
    ref_lo = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);
    issue(0, 32'h7FFF_FFFF, 32'd2, 15, st);
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);

    // MT then MF one cycle later; MT stalled by a MULT.
    issue(1, 32'hDEAD_BEEF, 0, 0, st);
    issue(3, 0, 0, 0, st);
    issue(0, 32'd9, 32'hFFFF_FFFE, 20, st);
    issue(2, 32'h1234_5678, 0, 0, st);
    check("mt_stall_cycles", 64'(st), 64'd21);
    issue(4, 0, 0, 0, st);
    issue(3, 0, 0, 0, st);

    // Overlapping requests: only the highest is served.
    issue(6, 32'hCAFE_F00D, 0, 0, st);
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);
    issue(5, 32'd9, 32'd9, 3, st);
    issue(4, 0, 0, 0, st);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       l = 0;
        1:       l = 80;
        2:       l = 81;
        default: l = $urandom_range(1, 40);
      endcase
      issue($urandom_range(0, 6), $urandom, $urandom, l, st);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    issue(3, 0, 0, 0, st);
    issue(4, 0, 0, 0, st);

    for (int i = 0; i < 500 &&
         (rd_q.size() != 0 || len_q.size() != 0); i++)
      @(negedge clk);
    check("drain", 64'(rd_q.size() + len_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
